psdi_i2s_tx: RTL and testbench

PSDI_I2S_TX -- requirements
Module: psdi_i2s_tx

---
 rtl/psdi_audio_pkg.sv | 17 +
 rtl/psdi_i2s_bclk_gen.sv | 58 +++++
 rtl/psdi_i2s_tx.sv | 118 +++++++++++
 tb/tb_psdi_i2s_tx.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/psdi_audio_pkg.sv
// Shared audio constants and the I2S transmitter FSM state type.
//   SAMPLE_W   : width of one signed PCM sample
//   SLOT_BITS  : bclk periods per channel slot
//   FRAME_BITS : bclk periods per stereo frame (left + right slot)
package psdi_audio_pkg;

    localparam int unsigned SAMPLE_W   = 18;
    localparam int unsigned SLOT_BITS  = 32;
    localparam int unsigned FRAME_BITS = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } tx_state_e;

endpackage

// File: rtl/psdi_i2s_bclk_gen.sv
// Bit-clock divider for the I2S transmitter.
//   clk_i, rst_ni : system clock, async active-low reset
//   run_i         : high while the transmitter is framing; low parks bclk at 0
//   bclk_o        : registered bit clock, toggles every BCLK_DIV clocks
//   fall_o        : combinational, high in the cycle whose edge drops bclk
//                   (the edge on which lrck/sdata must be updated)
module psdi_i2s_bclk_gen #(
    parameter int unsigned BCLK_DIV = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic run_i,
    output logic bclk_o,
    output logic fall_o
);

    localparam logic [7:0] DIV_LAST = 8'(BCLK_DIV - 1);

    logic [7:0] div_q, div_d;
    logic       bclk_q, bclk_d;
    logic       first_q, first_d;
    logic       tc;

    assign tc = run_i && (div_q == DIV_LAST);

    // The first terminal count after leaving idle counts as a fall event
    // (bclk is already low), so the first frame starts BCLK_DIV clocks in.
    assign fall_o = tc && (bclk_q || first_q);
    assign bclk_o = bclk_q;

    always_comb begin
        div_d   = div_q + 8'd1;
        bclk_d  = bclk_q;
        first_d = first_q;
        if (!run_i) begin
            div_d   = 8'd0;
            bclk_d  = 1'b0;
            first_d = 1'b1;
        end else if (tc) begin
            div_d   = 8'd0;
            first_d = 1'b0;
            bclk_d  = first_q ? 1'b0 : ~bclk_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_q   <= 8'd0;
            bclk_q  <= 1'b0;
            first_q <= 1'b1;
        end else begin
            div_q   <= div_d;
            bclk_q  <= bclk_d;
            first_q <= first_d;
        end
    end

endmodule

// File: rtl/psdi_i2s_tx.sv
// I2S stereo transmitter: 64-bit frames, 18-bit samples MSB first with a
// one-bit delay after lrck changes, zero padded to 32 bits per slot.
//   clk_i, rst_ni        : system clock, async active-low reset
//   enable_i             : 1 = send frames, 0 = finish current frame then idle
//   data_en_i            : one-cycle sample strobe; captures left_i/right_i
//   left_i, right_i      : signed samples
//   bclk_o, lrck_o       : registered bit clock / word select (0 = left)
//   sdata_o              : registered serial data
//   frame_start_o        : pulse when a new frame is loaded
//   underrun_o           : pulse with frame_start_o when no new sample arrived
module psdi_i2s_tx
    import psdi_audio_pkg::*;
#(
    parameter int unsigned BCLK_DIV = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                enable_i,
    input  logic                data_en_i,
    input  logic [SAMPLE_W-1:0] left_i,
    input  logic [SAMPLE_W-1:0] right_i,
    output logic                bclk_o,
    output logic                lrck_o,
    output logic                sdata_o,
    output logic                frame_start_o,
    output logic                underrun_o
);

    localparam logic [5:0] BIT_LAST = 6'(FRAME_BITS - 1);

    tx_state_e           state_q;
    logic [5:0]          bit_q, bit_d;
    logic [SAMPLE_W-1:0] hold_l_q, hold_r_q, sh_l_q, sh_r_q, slot;
    logic                pending_q, lrck_q, sdata_q, fs_q, ur_q;
    logic                fall, run_eff, wrap, load, sdata_d;
    logic [4:0]          pos, idx;

    psdi_i2s_bclk_gen #(.BCLK_DIV(BCLK_DIV)) u_bclk (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .run_i  (state_q != ST_IDLE),
        .bclk_o (bclk_o),
        .fall_o (fall)
    );

    // DRAIN with enable back high behaves as RUN, so there is no gap.
    assign run_eff = (state_q == ST_RUN) || (state_q == ST_DRAIN && enable_i);
    assign wrap    = (bit_q == BIT_LAST);
    assign load    = fall && wrap && run_eff;

    always_comb begin
        bit_d   = bit_q + 6'd1;
        pos     = 5'(bit_d % 6'(SLOT_BITS));
        slot    = bit_d[5] ? sh_r_q : sh_l_q;
        idx     = 5'(SAMPLE_W) - pos;
        sdata_d = 1'b0;
        if (pos != 5'd0 && pos <= 5'(SAMPLE_W))
            sdata_d = slot[idx];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            bit_q     <= BIT_LAST;
            hold_l_q  <= '0;
            hold_r_q  <= '0;
            sh_l_q    <= '0;
            sh_r_q    <= '0;
            pending_q <= 1'b0;
            lrck_q    <= 1'b0;
            sdata_q   <= 1'b0;
            fs_q      <= 1'b0;
            ur_q      <= 1'b0;
        end else begin
            fs_q <= 1'b0;
            ur_q <= 1'b0;
            if (data_en_i) begin
                hold_l_q <= left_i;
                hold_r_q <= right_i;
            end
            // A strobe coinciding with a load stays pending for the next frame.
            pending_q <= data_en_i | (pending_q & ~load);

            unique case (state_q)
                ST_IDLE:  if (enable_i)  state_q <= ST_RUN;
                ST_RUN:   if (!enable_i) state_q <= ST_DRAIN;
                ST_DRAIN: if (enable_i)  state_q <= ST_RUN;
                default:  state_q <= ST_IDLE;
            endcase

            if (fall) begin
                if (wrap && !run_eff) begin
                    state_q <= ST_IDLE;
                    bit_q   <= BIT_LAST;
                    lrck_q  <= 1'b0;
                    sdata_q <= 1'b0;
                end else begin
                    bit_q   <= bit_d;
                    lrck_q  <= bit_d[5];
                    sdata_q <= sdata_d;
                    if (wrap) begin
                        // Underrun simply resends the old hold contents.
                        sh_l_q <= hold_l_q;
                        sh_r_q <= hold_r_q;
                        fs_q   <= 1'b1;
                        ur_q   <= ~pending_q;
                    end
                end
            end
        end
    end

    assign lrck_o        = lrck_q;
    assign sdata_o       = sdata_q;
    assign frame_start_o = fs_q;
    assign underrun_o    = ur_q;

endmodule

// File: tb/tb_psdi_i2s_tx.sv
module tb_psdi_i2s_tx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        data_en = 1'b0;
    logic [17:0] left = '0;
    logic [17:0] right = '0;
    logic        bclk, lrck, sdata, frame_start, underrun;

    int checks = 0;
    int failures = 0;
    int viol = 0;
    logic prev_sd = 1'b0, prev_bclk = 1'b0, prev_rst = 1'b0;

    localparam logic [63:0] LR_EXP = 64'hFFFF_FFFF_0000_0000;

    psdi_i2s_tx #(.BCLK_DIV(2)) dut (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .data_en_i(data_en),
        .left_i(left), .right_i(right), .bclk_o(bclk), .lrck_o(lrck),
        .sdata_o(sdata), .frame_start_o(frame_start), .underrun_o(underrun)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // sdata may only move on the edge where bclk drops 1 -> 0.
    always @(negedge clk) begin
        if (rst_n && prev_rst && sdata !== prev_sd && !(prev_bclk && !bclk))
            viol++;
        prev_sd   <= sdata;
        prev_bclk <= bclk;
        prev_rst  <= rst_n;
    end

    function automatic logic [63:0] exp_sd(input logic [17:0] l, input logic [17:0] r);
        logic [63:0] f;
        logic [17:0] s;
        int p;
        f = '0;
        for (int n = 0; n < 64; n++) begin
            p = n % 32;
            s = (n < 32) ? l : r;
            if (p >= 1 && p <= 18) f[n] = s[18 - p];
        end
        return f;
    endfunction

    task automatic wait_fs(output int k);
        k = 0;
        while (!frame_start && k < 600) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic capture(output logic [63:0] sd, output logic [63:0] lr,
                           output logic ur, output logic ok);
        int k;
        wait_fs(k);
        ok = frame_start;
        ur = underrun;
        sd[0] = sdata;
        lr[0] = lrck;
        for (int n = 1; n < 64; n++) begin
            repeat (4) @(negedge clk);
            sd[n] = sdata;
            lr[n] = lrck;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (bclk !== 1'b0) begin failures++; $display("FAIL reset_bclk got=%b exp=0", bclk); end
        checks++; if (lrck !== 1'b0) begin failures++; $display("FAIL reset_lrck got=%b exp=0", lrck); end
        checks++; if (sdata !== 1'b0) begin failures++; $display("FAIL reset_sdata got=%b exp=0", sdata); end
        checks++; if (frame_start !== 1'b0) begin failures++; $display("FAIL reset_fs got=%b exp=0", frame_start); end
        checks++; if (underrun !== 1'b0) begin failures++; $display("FAIL reset_ur got=%b exp=0", underrun); end
    endtask

    task automatic test_first_frame();
        logic [63:0] sd, lr;
        logic ur, ok;
        int k;
        rst_n = 1'b1; enable = 1'b1;
        data_en = 1'b1; left = 18'h2AAAA; right = 18'h15555;
        @(negedge clk);
        data_en = 1'b0;
        wait_fs(k);
        checks++; if (k !== 2) begin failures++; $display("FAIL first_latency got=%0d exp=2 negedges after strobe", k); end
        capture(sd, lr, ur, ok);
        checks++; if (ok !== 1'b1 || ur !== 1'b0) begin failures++; $display("FAIL first_ur got ok=%b ur=%b exp ok=1 ur=0", ok, ur); end
        checks++; if (sd !== exp_sd(18'h2AAAA, 18'h15555)) begin failures++; $display("FAIL first_sdata got=%h exp=%h", sd, exp_sd(18'h2AAAA, 18'h15555)); end
        checks++; if (lr !== LR_EXP) begin failures++; $display("FAIL first_lrck got=%h exp=%h", lr, LR_EXP); end
    endtask

    task automatic test_underrun();
        logic [63:0] sd, lr;
        logic ur, ok;
        for (int f = 0; f < 2; f++) begin
            capture(sd, lr, ur, ok);
            checks++; if (ok !== 1'b1 || ur !== 1'b1) begin failures++; $display("FAIL underrun_flag%0d got ok=%b ur=%b exp ok=1 ur=1", f, ok, ur); end
            checks++; if (sd !== exp_sd(18'h2AAAA, 18'h15555)) begin failures++; $display("FAIL underrun_data%0d got=%h exp=%h", f, sd, exp_sd(18'h2AAAA, 18'h15555)); end
        end
    endtask

    task automatic test_load_collision();
        logic [63:0] sd, lr;
        logic ur, ok;
        // Previous capture ends in bit 63; the load edge follows the 3rd negedge.
        repeat (3) @(negedge clk);
        data_en = 1'b1; left = 18'h3FFFF; right = 18'h00001;
        @(negedge clk);
        data_en = 1'b0;
        checks++; if (frame_start !== 1'b1) begin failures++; $display("FAIL coll_align fs got=%b exp=1", frame_start); end
        capture(sd, lr, ur, ok);
        checks++; if (sd !== exp_sd(18'h2AAAA, 18'h15555)) begin failures++; $display("FAIL coll_old got=%h exp=%h", sd, exp_sd(18'h2AAAA, 18'h15555)); end
        capture(sd, lr, ur, ok);
        checks++; if (ok !== 1'b1 || ur !== 1'b0) begin failures++; $display("FAIL coll_new_ur got ok=%b ur=%b exp ok=1 ur=0", ok, ur); end
        checks++; if (sd !== exp_sd(18'h3FFFF, 18'h00001)) begin failures++; $display("FAIL coll_new_data got=%h exp=%h", sd, exp_sd(18'h3FFFF, 18'h00001)); end
    endtask

    task automatic test_drain();
        int k, bad;
        wait_fs(k);
        repeat (40) @(negedge clk);
        enable = 1'b0;
        repeat (213) @(negedge clk);
        checks++; if (lrck !== 1'b1) begin failures++; $display("FAIL drain_bit63_lrck got=%b exp=1", lrck); end
        repeat (4) @(negedge clk);
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            if (bclk || lrck || sdata || frame_start) bad++;
            @(negedge clk);
        end
        checks++; if (bad !== 0) begin failures++; $display("FAIL drain_idle active_cycles got=%0d exp=0", bad); end
    endtask

    task automatic test_restart_lrck();
        int k, per;
        enable = 1'b1;
        wait_fs(k);
        checks++; if (k !== 3) begin failures++; $display("FAIL restart_latency got=%0d exp=3", k); end
        k = 0;
        while (lrck !== 1'b1 && k < 600) begin @(negedge clk); k++; end
        per = 0;
        while (lrck !== 1'b0 && per < 600) begin @(negedge clk); per++; end
        while (lrck !== 1'b1 && per < 600) begin @(negedge clk); per++; end
        checks++; if (per !== 256) begin failures++; $display("FAIL lrck_period got=%0d exp=256", per); end
    endtask

    task automatic test_reset_mid();
        logic [63:0] sd, lr;
        logic ur, ok;
        int k;
        wait_fs(k);
        repeat (160) @(negedge clk);
        checks++; if (lrck !== 1'b1) begin failures++; $display("FAIL mid_pre_lrck got=%b exp=1", lrck); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({bclk, lrck, sdata, frame_start, underrun} !== 5'b0) begin
            failures++; $display("FAIL mid_async_outs got=%b exp=00000", {bclk, lrck, sdata, frame_start, underrun}); end
        @(negedge clk);
        rst_n = 1'b1;
        wait_fs(k);
        checks++; if (k !== 3) begin failures++; $display("FAIL mid_restart_latency got=%0d exp=3", k); end
        capture(sd, lr, ur, ok);
        checks++; if (ur !== 1'b1 || sd !== 64'h0) begin failures++; $display("FAIL mid_cleared got ur=%b sd=%h exp ur=1 sd=0", ur, sd); end
    endtask

    task automatic test_sdata_edges();
        checks++; if (viol !== 0) begin failures++; $display("FAIL sdata_edge violations got=%0d exp=0", viol); end
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_underrun();
        test_load_collision();
        test_drain();
        test_restart_lrck();
        test_reset_mid();
        test_sdata_edges();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
